// File: rtl/elastic_delay_line.sv
// elastic_delay_line: DEPTH-stage WIDTH-bit register pipeline with per-stage valids,
// valid/ready handshakes on both sides, bubble collapse and synchronous flush.
module elastic_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] w_take;
  logic             w_acc;
  logic             w_hs;
  // A stage can take a word when the sink is ready or any stage at or after it is empty.
  always_comb begin
    w_take = '0;
    for (int i = 0; i < DEPTH; i++)
      w_take[i] = out_ready || !(&(r_v | DEPTH'((DEPTH'(1) << i) - DEPTH'(1))));
  end
  assign w_acc     = in_valid && !flush && w_take[0];
  assign w_hs      = r_v[DEPTH-1] && out_ready;
  assign in_ready  = reset_n && !flush && w_take[0];
  assign data_out  = r_d[DEPTH-1];
  assign out_valid = r_v[DEPTH-1];
  assign count     = r_count;
  // Data only loads behind a valid word, so data_out holds its last value once drained.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      if (w_take[0]) begin
        r_v[0] <= w_acc;
        if (w_acc) r_d[0] <= data_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_take[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) r_d[i] <= r_d[i-1];
        end
      end
      r_count <= r_count + CW'(w_acc) - CW'(w_hs);
    end
  end
endmodule

// File: tb/tb_elastic_delay_line.sv
// tb_elastic_delay_line: directed vector table over a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=16 instance,
// plus a hand-written asynchronous reset sequence.
module tb_elastic_delay_line;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  a_din = '0;
  logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_fl = 1'b0;
  logic [7:0]  a_dout;
  logic [2:0]  a_cnt;
  logic [15:0] b_din = '0;
  logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_fl = 1'b0;
  logic [15:0] b_dout;
  logic [0:0]  b_cnt;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  elastic_delay_line #(.WIDTH(8), .DEPTH(4)) u_a (
    .clock(clock), .reset_n(reset_n), .data_in(a_din), .in_valid(a_iv), .in_ready(a_ir),
    .data_out(a_dout), .out_valid(a_ov), .out_ready(a_or), .flush(a_fl), .count(a_cnt));

  elastic_delay_line #(.WIDTH(16), .DEPTH(1)) u_b (
    .clock(clock), .reset_n(reset_n), .data_in(b_din), .in_valid(b_iv), .in_ready(b_ir),
    .data_out(b_dout), .out_valid(b_ov), .out_ready(b_or), .flush(b_fl), .count(b_cnt));

  typedef struct {
    bit          sel;
    bit          iv;
    logic [15:0] d;
    bit          ordy;
    bit          fl;
    bit          e_ir;
    bit          e_ov;
    logic [15:0] e_do;
    int          e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit sel, bit iv, logic [15:0] d, bit ordy, bit fl,
                              bit e_ir, bit e_ov, logic [15:0] e_do, int e_cnt);
    vec_t v;
    v.sel = sel; v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_do = e_do; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_a(bit iv, logic [7:0] d, bit ordy, bit fl);
    a_iv = iv; a_din = d; a_or = ordy; a_fl = fl;
  endtask

  initial begin
    // stream 32,28,109,111 with sink always ready
    vt.push_back(mk(0, 1, 32,  1, 0, 1, 0, 0,   0));
    vt.push_back(mk(0, 1, 28,  1, 0, 1, 0, 0,   1));
    vt.push_back(mk(0, 1, 109, 1, 0, 1, 0, 0,   2));
    vt.push_back(mk(0, 1, 111, 1, 0, 1, 0, 0,   3));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 32,  4));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 28,  3));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 109, 2));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 111, 1));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 111, 0));
    // backpressure: 1,74,0,112,221 with sink stalled
    vt.push_back(mk(0, 1, 1,   0, 0, 1, 0, 111, 0));
    vt.push_back(mk(0, 1, 74,  0, 0, 1, 0, 111, 1));
    vt.push_back(mk(0, 1, 0,   0, 0, 1, 0, 111, 2));
    vt.push_back(mk(0, 1, 112, 0, 0, 1, 0, 111, 3));
    vt.push_back(mk(0, 1, 221, 0, 0, 0, 1, 1,   4));
    vt.push_back(mk(0, 1, 221, 0, 0, 0, 1, 1,   4));
    vt.push_back(mk(0, 1, 221, 1, 0, 1, 1, 1,   4));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 74,  4));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 0,   3));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 112, 2));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 221, 1));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 221, 0));
    // bubble collapse under stall
    vt.push_back(mk(0, 1, 5,   0, 0, 1, 0, 221, 0));
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 0, 221, 1));
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 0, 221, 1));
    vt.push_back(mk(0, 1, 6,   0, 0, 1, 0, 221, 1));
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 1, 5,   2));
    vt.push_back(mk(0, 0, 0,   0, 0, 1, 1, 5,   2));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 5,   2));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 1, 6,   1));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 6,   0));
    // flush with a word offered in the same cycle
    vt.push_back(mk(0, 1, 7,   0, 0, 1, 0, 6,   0));
    vt.push_back(mk(0, 1, 8,   0, 0, 1, 0, 6,   1));
    vt.push_back(mk(0, 1, 9,   0, 0, 1, 0, 6,   2));
    vt.push_back(mk(0, 1, 99,  0, 1, 0, 0, 6,   3));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 6,   0));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 6,   0));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 6,   0));
    vt.push_back(mk(0, 0, 0,   1, 0, 1, 0, 6,   0));
    // DEPTH=1 WIDTH=16 with toggling sink
    vt.push_back(mk(1, 1, 16'hFFFF, 0, 0, 1, 0, 16'h0000, 0));
    vt.push_back(mk(1, 1, 16'h0001, 1, 0, 1, 1, 16'hFFFF, 1));
    vt.push_back(mk(1, 1, 16'h1234, 0, 0, 0, 1, 16'h0001, 1));
    vt.push_back(mk(1, 0, 16'h0000, 1, 0, 1, 1, 16'h0001, 1));
    vt.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 0, 16'h0001, 0));

    #3;
    chk("rst_ir_a", 0, 32'(a_ir), 0);
    chk("rst_ov_a", 0, 32'(a_ov), 0);
    chk("rst_do_a", 0, 32'(a_dout), 0);
    chk("rst_cnt_a", 0, 32'(a_cnt), 0);
    chk("rst_ir_b", 0, 32'(b_ir), 0);
    chk("rst_do_b", 0, 32'(b_dout), 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vt[k]) begin
      @(negedge clock);
      if (vt[k].sel) begin
        drive_a(0, 0, 0, 0);
        b_iv = vt[k].iv; b_din = vt[k].d; b_or = vt[k].ordy; b_fl = vt[k].fl;
      end else begin
        drive_a(vt[k].iv, vt[k].d[7:0], vt[k].ordy, vt[k].fl);
        b_iv = 0; b_din = 0; b_or = 0; b_fl = 0;
      end
      #1;
      chk("in_ready", k, vt[k].sel ? 32'(b_ir) : 32'(a_ir), 32'(vt[k].e_ir));
      chk("out_valid", k, vt[k].sel ? 32'(b_ov) : 32'(a_ov), 32'(vt[k].e_ov));
      chk("data_out", k, vt[k].sel ? 32'(b_dout) : 32'(a_dout), 32'(vt[k].e_do));
      chk("count", k, vt[k].sel ? 32'(b_cnt) : 32'(a_cnt), 32'(vt[k].e_cnt));
    end

    b_iv = 0; b_or = 0;
    @(negedge clock); drive_a(1, 10, 0, 0);
    @(negedge clock); drive_a(1, 20, 0, 0);
    @(negedge clock); drive_a(1, 30, 0, 0);
    @(negedge clock); drive_a(0, 0, 0, 0);
    @(negedge clock); #1;
    chk("pre_rst_ov", 0, 32'(a_ov), 1);
    chk("pre_rst_do", 0, 32'(a_dout), 10);
    chk("pre_rst_cnt", 0, 32'(a_cnt), 3);
    drive_a(1, 40, 1, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ov", 0, 32'(a_ov), 0);
    chk("async_rst_do", 0, 32'(a_dout), 0);
    chk("async_rst_cnt", 0, 32'(a_cnt), 0);
    chk("async_rst_ir", 0, 32'(a_ir), 0);
    @(negedge clock);
    drive_a(0, 0, 1, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ir", 0, 32'(a_ir), 1);
    chk("post_rst_ov", 0, 32'(a_ov), 0);
    chk("post_rst_cnt", 0, 32'(a_cnt), 0);
    @(negedge clock); #1;
    chk("post_rst_idle_ov", 0, 32'(a_ov), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
